// File: rtl/cart_unlock_host.sv
`default_nettype none
// ============================================================================
//  Module   : cart_unlock_host
//  Purpose  : Console-side initiator for the cartridge unlock handshake:
//             reset pulse, 5A/A5 address steps, SO frame capture and check.
//  Revision : 1.0
// ============================================================================
module cart_unlock_host #(
    parameter logic [15:0] EXP_WORD   = 16'h28A0,
    parameter int          RST_CYCLES = 4,
    parameter int          TIMEOUT    = 32,
    parameter int          MAX_RETRY  = 2,
    parameter logic [7:0]  ADDR_IDLE  = 8'hFF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    input  logic        SI,
    output logic        CART_RSTn,
    output logic [7:0]  ADDR_OUT,
    output logic        BUSY,
    output logic        DONE,
    output logic        OK,
    output logic        ERR_TIMEOUT,
    output logic        ERR_FRAME,
    output logic [15:0] RX_WORD
);

    localparam int CNT_MAX_A = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > 16) ? CNT_MAX_A : 16;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(15);
    localparam logic [2:0]       RETRY_LIM  = 3'(MAX_RETRY);
    localparam logic [7:0]       ADDR_ACK   = 8'h5A;
    localparam logic [7:0]       ADDR_NAK   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_ACK   = 3'd2,
        S_NAK   = 3'd3,
        S_WAIT  = 3'd4,
        S_SHIFT = 3'd5,
        S_STOP  = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       retry;
    logic [2:0]       retry_n;
    logic             clear_flags;
    logic             set_ok;
    logic             set_to;
    logic             set_fr;
    logic             shift_en;
    logic             fail_to;
    logic             fail_fr;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            retry <= retry_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        retry_n     = retry;
        clear_flags = 1'b0;
        set_ok      = 1'b0;
        set_to      = 1'b0;
        set_fr      = 1'b0;
        shift_en    = 1'b0;
        fail_to     = 1'b0;
        fail_fr     = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (START) begin
                    clear_flags = 1'b1;
                    retry_n     = '0;
                    state_n     = S_CRST;
                end
            end
            S_CRST: begin
                if (cnt == RST_LAST) begin
                    cnt_n   = '0;
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                cnt_n   = '0;
                state_n = S_NAK;
            end
            S_NAK: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // A start bit on the final allowed cycle still counts.
                if (!SI) begin
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end else if (cnt == WAIT_LAST) begin
                    fail_to = 1'b1;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == SHIFT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                cnt_n = '0;
                if (!SI && (RX_WORD == EXP_WORD)) begin
                    set_ok  = 1'b1;
                    state_n = S_FIN;
                end else begin
                    fail_fr = 1'b1;
                end
            end
            S_FIN: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase

        // Errors are only reported once the retry budget is exhausted.
        if (fail_to || fail_fr) begin
            cnt_n = '0;
            if (retry < RETRY_LIM) begin
                retry_n = retry + 3'd1;
                state_n = S_CRST;
            end else begin
                set_to  = fail_to;
                set_fr  = fail_fr;
                state_n = S_FIN;
            end
        end
    end

    // Outputs are registered decodes of the next state so they line up with it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            CART_RSTn   <= 1'b1;
            ADDR_OUT    <= ADDR_IDLE;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            OK          <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            ERR_FRAME   <= 1'b0;
            RX_WORD     <= '0;
        end else begin
            CART_RSTn <= (state_n != S_CRST);
            BUSY      <= (state_n != S_IDLE) && (state_n != S_FIN);
            DONE      <= (state_n == S_FIN);
            case (state_n)
                S_ACK:   ADDR_OUT <= ADDR_ACK;
                S_NAK:   ADDR_OUT <= ADDR_NAK;
                default: ADDR_OUT <= ADDR_IDLE;
            endcase

            if (clear_flags) begin
                OK          <= 1'b0;
                ERR_TIMEOUT <= 1'b0;
                ERR_FRAME   <= 1'b0;
            end
            if (set_ok) begin
                OK <= 1'b1;
            end
            if (set_to) begin
                ERR_TIMEOUT <= 1'b1;
            end
            if (set_fr) begin
                ERR_FRAME <= 1'b1;
            end
            if (shift_en) begin
                RX_WORD <= {SI, RX_WORD[15:1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cart_unlock_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cart_unlock_host
//  Purpose  : Bench for cart_unlock_host with a bit-queue cartridge model.
//  Revision : 1.0
// ============================================================================
module tb_cart_unlock_host;

    localparam logic [15:0] EXP        = 16'h28A0;
    localparam int          RST_CYC    = 4;
    localparam int          TMO        = 32;
    localparam int          RETRIES    = 2;

    logic        CLK   = 1'b0;
    logic        RSTn  = 1'b0;
    logic        START = 1'b0;
    logic        SI    = 1'b1;

    logic        cart_rstn, busy, done, ok, err_to, err_fr;
    logic [7:0]  addr_out;
    logic [15:0] rx_word;
    logic        cart_rstn0, busy0, done0, ok0, err_to0, err_fr0;
    logic [7:0]  addr_out0;
    logic [15:0] rx_word0;

    cart_unlock_host dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .SI(SI),
        .CART_RSTn(cart_rstn), .ADDR_OUT(addr_out), .BUSY(busy), .DONE(done),
        .OK(ok), .ERR_TIMEOUT(err_to), .ERR_FRAME(err_fr), .RX_WORD(rx_word)
    );

    cart_unlock_host #(.MAX_RETRY(0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .START(START), .SI(SI),
        .CART_RSTn(cart_rstn0), .ADDR_OUT(addr_out0), .BUSY(busy0), .DONE(done0),
        .OK(ok0), .ERR_TIMEOUT(err_to0), .ERR_FRAME(err_fr0), .RX_WORD(rx_word0)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cartridge: per-attempt frame description, consumed one attempt per A5 step.
    logic [15:0] c_pay  [0:2];
    logic        c_stp  [0:2];
    logic        c_pres [0:2];
    int          c_dly  [0:2];
    int          c_att     = 0;
    bit          c_pending = 1'b0;
    logic        q[$];

    initial begin : cartridge
        forever begin
            @(posedge CLK);
            #1;
            if (!RSTn || !cart_rstn) begin
                c_pending = 1'b0;
                q.delete();
                SI = 1'b1;
            end else begin
                if (c_pending) begin
                    c_pending = 1'b0;
                    q.delete();
                    if (c_att < 3 && c_pres[c_att]) begin
                        for (int i = 0; i < c_dly[c_att]; i++) q.push_back(1'b1);
                        q.push_back(1'b0);
                        for (int i = 0; i < 16; i++) q.push_back(c_pay[c_att][i]);
                        q.push_back(c_stp[c_att]);
                    end
                    c_att++;
                end
                if (q.size() > 0) SI = q.pop_front();
                else SI = 1'b1;
                if (addr_out == 8'hA5) c_pending = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [2:0][15:0] pay;
        logic [2:0]       stp;
        logic [2:0]       pres;
        int               d0;
        logic             eok;
        logic             eto;
        logic             efr;
        int               epul;
        int               elat;
        logic [15:0]      erx;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] p0, input logic [15:0] p1,
                                input logic [15:0] p2, input logic [2:0] stp,
                                input logic [2:0] pres, input int d0,
                                input logic eok, input logic eto, input logic efr,
                                input int epul, input int elat, input logic [15:0] erx);
        vec_t v;
        v.pay[0] = p0; v.pay[1] = p1; v.pay[2] = p2;
        v.stp = stp; v.pres = pres; v.d0 = d0;
        v.eok = eok; v.eto = eto; v.efr = efr;
        v.epul = epul; v.elat = elat; v.erx = erx;
        return v;
    endfunction

    task automatic load_cart(input vec_t v);
        for (int a = 0; a < 3; a++) begin
            c_pay[a]  = v.pay[a];
            c_stp[a]  = v.stp[a];
            c_pres[a] = v.pres[a];
            c_dly[a]  = (a == 0) ? v.d0 : 0;
        end
        c_att = 0;
    endtask

    // Pulses START, then watches until DONE; latency counted in edges after E0.
    task automatic run(input bit extra, output int lat, output int pulses,
                       output int n5a, output int na5, output int lat0, output bit flag_bad);
        bit prev;
        lat = -1; lat0 = -1; pulses = 0; n5a = 0; na5 = 0; flag_bad = 1'b0; prev = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (ok || err_to || err_fr || !busy) flag_bad = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
            end
            START = (extra && k == 10);
            if (!cart_rstn && prev) pulses++;
            prev = cart_rstn;
            if (addr_out == 8'h5A) n5a++;
            if (addr_out == 8'hA5) na5++;
            if (ok && (err_to || err_fr)) flag_bad = 1'b1;
            if (done0 && lat0 < 0) lat0 = k;
            if (done) begin
                lat = k;
                break;
            end
        end
        START = 1'b0;
        @(posedge CLK);
        #1;
        if (done || busy) flag_bad = 1'b1;
    endtask

    // Reference: walk the attempts with the handshake rules in plain arithmetic.
    task automatic model(output logic eok, output logic eto, output logic efr,
                         output int epul, output int elat, inout logic [15:0] erx);
        eok = 0; eto = 0; efr = 0; epul = 0; elat = 0;
        for (int a = 0; a <= RETRIES; a++) begin
            epul = a + 1;
            eto = 0; efr = 0;
            if (!c_pres[a]) begin
                elat += RST_CYC + 2 + TMO;
                eto = 1;
            end else begin
                elat += RST_CYC + 2 + c_dly[a] + 1 + 16 + 1;
                erx = c_pay[a];
                if (!c_stp[a] && c_pay[a] == EXP) begin
                    eok = 1;
                    break;
                end
                efr = 1;
            end
        end
    endtask

    vec_t        vecs [7];
    int          lat, pulses, n5a, na5, lat0;
    bit          fbad;
    logic        eok, eto, efr;
    int          epul, elat;
    logic [15:0] model_rx;
    bit          idle_bad;

    task automatic chk_run(input string nm, input logic eok_i, input logic eto_i,
                           input logic efr_i, input int epul_i, input int elat_i,
                           input logic [15:0] erx_i);
        chk({nm, " ok"}, ok, eok_i);
        chk({nm, " err_timeout"}, err_to, eto_i);
        chk({nm, " err_frame"}, err_fr, efr_i);
        chk({nm, " rx_word"}, rx_word, erx_i);
        chk({nm, " rst_pulses"}, pulses, epul_i);
        chk({nm, " done_latency"}, lat, elat_i);
        chk({nm, " addr_steps"}, {n5a[15:0], na5[15:0]}, {epul_i[15:0], epul_i[15:0]});
        chk({nm, " protocol_flags"}, fbad, 0);
    endtask

    initial begin
        vecs[0] = mk(16'h28A0, 16'h0000, 16'h0000, 3'b000, 3'b001,  0, 1, 0, 0, 1,  24, 16'h28A0);
        vecs[1] = mk(16'h28A1, 16'h28A1, 16'h28A1, 3'b000, 3'b111,  0, 0, 0, 1, 3,  72, 16'h28A1);
        vecs[2] = mk(16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000,  0, 0, 1, 0, 3, 114, 16'h28A1);
        vecs[3] = mk(16'h28A0, 16'h28A0, 16'h0000, 3'b001, 3'b011,  0, 1, 0, 0, 2,  48, 16'h28A0);
        vecs[4] = mk(16'h28A0, 16'h0000, 16'h0000, 3'b000, 3'b001, 31, 1, 0, 0, 1,  55, 16'h28A0);
        vecs[5] = mk(16'h0000, 16'h28A0, 16'h0000, 3'b000, 3'b010,  0, 1, 0, 0, 2,  62, 16'h28A0);
        vecs[6] = mk(16'h1234, 16'h0000, 16'h0000, 3'b000, 3'b001,  0, 0, 1, 0, 3, 100, 16'h1234);

        repeat (3) @(posedge CLK);
        #1;
        chk("reset outputs", {cart_rstn, addr_out, busy, done, ok, err_to, err_fr, rx_word},
            {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        RSTn = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle after reset", {cart_rstn, addr_out, busy, done}, {1'b1, 8'hFF, 1'b0, 1'b0});

        for (int i = 0; i < 7; i++) begin
            load_cart(vecs[i]);
            run(1'b0, lat, pulses, n5a, na5, lat0, fbad);
            chk_run($sformatf("vec%0d", i), vecs[i].eok, vecs[i].eto, vecs[i].efr,
                    vecs[i].epul, vecs[i].elat, vecs[i].erx);
        end

        // Reset dropped while the 8th payload bit is being sampled.
        load_cart(vecs[0]);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (14) @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        chk("midop reset outputs", {cart_rstn, addr_out, busy, done, ok, err_to, err_fr, rx_word},
            {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        #10;
        RSTn = 1'b1;
        idle_bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK);
            #1;
            if (busy || done || !cart_rstn || addr_out != 8'hFF) idle_bad = 1'b1;
        end
        chk("idle holds after reset", idle_bad, 1'b0);

        load_cart(vecs[0]);
        run(1'b1, lat, pulses, n5a, na5, lat0, fbad);
        chk_run("start_while_busy", 1, 0, 0, 1, 24, 16'h28A0);

        load_cart(vecs[1]);
        run(1'b0, lat, pulses, n5a, na5, lat0, fbad);
        chk("noretry done_latency", lat0, 24);
        chk("noretry flags", {ok0, err_to0, err_fr0}, 3'b001);
        chk("noretry rx_word", rx_word0, 16'h28A1);
        chk("noretry rst_idle", {cart_rstn0, busy0, addr_out0}, {1'b1, 1'b0, 8'hFF});
        chk("retry rst_pulses", pulses, 3);
        model_rx = 16'h28A1;

        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 3; a++) begin
                c_pres[a] = ($urandom % 4) != 0;
                c_dly[a]  = $urandom % TMO;
                c_pay[a]  = (($urandom % 3) == 0) ? 16'($urandom) : EXP;
                c_stp[a]  = ($urandom % 4) == 0;
            end
            c_att = 0;
            model(eok, eto, efr, epul, elat, model_rx);
            run(1'b0, lat, pulses, n5a, na5, lat0, fbad);
            chk_run($sformatf("rand%0d", it), eok, eto, efr, epul, elat, model_rx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
